fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and next-PC stage of the unpipelined MIPS core. It sits directly upstream of the main control decoder.
- It owns the PC register and runs a request/acknowledge fetch from instruction memory. It holds the fetched word and drives its opcode field into the decoder.
- It consumes the decoder's jump/beq/bne outputs plus the ALU zero flag to select the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- TIMEOUT_CYCLES, 16, max wait cycles for i_imem_ack before fault (used only with FETCH_TIMEOUT_EN).

Ports:
- i_clk  input  1  core clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- o_imem_req  output  1  fetch request, held until ack
- o_imem_addr  output  32  fetch address (= o_pc), stable while o_imem_req=1
- i_imem_ack  input  1  memory accepted request; i_imem_rdata valid this cycle
- i_imem_rdata  input  32  instruction word
- i_stall  input  1  extend current execute cycle (multi-cycle data memory)
- i_jump  input  1  decoder jump
- i_beq  input  1  decoder branch-if-equal
- i_bne  input  1  decoder branch-if-not-equal
- i_zero  input  1  ALU zero flag
- o_instr  output  32  held instruction word
- o_opcode  output  6  o_instr[31:26], feeds decoder opcode input
- o_pc  output  32  PC of held instruction
- o_pc_plus4  output  32  o_pc + 4, modulo 2^32
- o_instr_valid  output  1  high only in EXEC; downstream gates regfile/memory writes with it
- o_fault  output  1  fetch timeout fault (tied 0 without FETCH_TIMEOUT_EN)

Behaviour:
- Reset (async, i_rst_n=0): state=RESET, o_pc=RESET_PC, o_instr=0, o_imem_req=0, o_instr_valid=0, o_fault=0, timeout counter=0.
- States: RESET -> FETCH (unconditional, 1 cycle after reset release). FETCH -> EXEC on edge with i_imem_ack=1. EXEC -> FETCH on edge with i_stall=0. EXEC -> EXEC while i_stall=1.
- FETCH: o_imem_req=1, o_imem_addr=o_pc. On ack, register i_imem_rdata into o_instr. Ack in the first FETCH cycle gives the minimum fetch latency of 1 cycle.
- i_imem_ack outside FETCH is ignored; o_instr is unchanged.
- EXEC: o_instr_valid=1 and o_instr is stable. The decoder result is combinationally available from o_opcode.
- PC update happens only on the EXEC->FETCH edge. Priority:
  - i_jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - (i_beq & i_zero) | (i_bne & ~i_zero): pc_plus4 + (sign-extended instr[15:0] << 2), 32-bit wrap.
  - Otherwise: pc_plus4.
- i_jump has priority over branches if several are asserted. Both i_beq and i_bne asserted: beq term evaluated first, OR of the two terms applies.
- Control inputs are ignored outside EXEC and while i_stall=1. X/Z on them outside EXEC must not affect the PC.
- PC 32'hFFFF_FFFC + 4 wraps to 0. o_pc[1:0] is always 00.
- Reset mid-fetch or mid-stall: immediate return to reset values; the outstanding request is dropped. The memory must tolerate req deassertion without ack.
- Total cycles per instruction = fetch wait + 1 + stall cycles.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - Counter increments each FETCH cycle without ack and clears on ack.
  - When the counter reaches TIMEOUT_CYCLES, the block enters HALT: o_imem_req=0, o_instr_valid=0, o_fault=1.
  - HALT exits only by reset.
- Undefined: no counter, no HALT state, o_fault constant 0, FETCH waits indefinitely.

Test Plan:
- Reset release, ack immediate, rdata 32'h2008_0005 (addi): o_pc=0, o_opcode=6'h08, o_instr_valid 1 cycle; next fetch addr=4.
- EXEC at pc=32'h0000_0010, instr 32'h1109_FFFC, i_beq=1, i_zero=1: next o_imem_addr=32'h0000_0004. Same with i_zero=0: 32'h0000_0014.
- EXEC at pc=32'h1000_0000, instr 32'h0800_0040, i_jump=1, i_bne=1: next addr=32'h1000_0100 (jump priority).
- i_stall=1 for 3 EXEC cycles: o_instr_valid high 4 cycles, o_pc unchanged, no req; ack pulse injected during EXEC is ignored.
- RESET_PC=32'hFFFF_FFFC, sequential instr: second fetch addr=0. Assert i_rst_n=0 mid-FETCH: req drops same cycle, o_pc=RESET_PC.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never asserted: o_fault=1 after 4 FETCH cycles, req=0 and held until reset.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/ack, decoder and ALU controls, fetched-instruction outputs.
// master = fetch_unit side, slave = memory/decoder/environment side.
interface fetch_unit_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;

  logic            o_imem_req;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_ack;
  logic [XLEN-1:0] i_imem_rdata;
  logic            i_stall;
  logic            i_jump;
  logic            i_beq;
  logic            i_bne;
  logic            i_zero;
  logic [XLEN-1:0] o_instr;
  logic [OPW-1:0]  o_opcode;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_pc_plus4;
  logic            o_instr_valid;
  logic            o_fault;

  modport master (
    output o_imem_req, o_imem_addr, o_instr, o_opcode, o_pc, o_pc_plus4, o_instr_valid, o_fault,
    input  i_imem_ack, i_imem_rdata, i_stall, i_jump, i_beq, i_bne, i_zero
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_instr, o_opcode, o_pc, o_pc_plus4, o_instr_valid, o_fault,
    output i_imem_ack, i_imem_rdata, i_stall, i_jump, i_beq, i_bne, i_zero
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch and next-PC stage of the unpipelined MIPS core (RESET -> FETCH -> EXEC loop).
// Optional fetch timeout with HALT/fault is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic          i_clk,
  input logic          i_rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_RST    = {RESET_PC[XLEN-1:2], 2'b00};
  localparam logic [XLEN-1:0] PC_RST_P4 = PC_RST + XLEN'(4);

  if (RESET_PC[1:0] != 2'b00 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("fetch_unit: RESET_PC must be word aligned and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
`ifdef FETCH_TIMEOUT_EN
    , S_HALT = 2'd3
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] br_off;
  logic            take_br;
  logic [XLEN-1:0] target;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`endif

  // Next-PC select; jump beats branch, branch term is the OR of the beq and bne conditions
  always_comb begin
    br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    take_br = (bus.i_beq & bus.i_zero) | (bus.i_bne & ~bus.i_zero);
    if (bus.i_jump) begin
      target = {pc4_q[31:28], instr_q[25:0], 2'b00};
    end else if (take_br) begin
      target = pc4_q + br_off;
    end else begin
      target = pc4_q;
    end
  end

  // Next state and registered-output values
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    req_d   = 1'b0;
    valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    fault_d = 1'b0;
`endif
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.i_imem_ack) begin
          instr_d = bus.i_imem_rdata;
          state_d = S_EXEC;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef FETCH_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) state_d = S_HALT;
        end
`endif
      end
      // Control inputs are only looked at here, so X outside EXEC never reaches the PC
      S_EXEC: begin
        if (!bus.i_stall) begin
          state_d = S_FETCH;
          pc_d    = target;
          pc4_d   = target + XLEN'(4);
        end
      end
`ifdef FETCH_TIMEOUT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_RESET;
    endcase
    if (state_d == S_FETCH) req_d   = 1'b1;
    if (state_d == S_EXEC)  valid_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
    if (state_d == S_HALT)  fault_d = 1'b1;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_RESET;
      pc_q    <= PC_RST;
      pc4_q   <= PC_RST_P4;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  assign bus.o_fault = fault_q;
`else
  assign bus.o_fault = 1'b0;
`endif

  assign bus.o_imem_req    = req_q;
  assign bus.o_imem_addr   = pc_q;
  assign bus.o_pc          = pc_q;
  assign bus.o_pc_plus4    = pc4_q;
  assign bus.o_instr       = instr_q;
  assign bus.o_opcode      = instr_q[31:26];
  assign bus.o_instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: three instances (different RESET_PC) share one stimulus stream
// and are compared every cycle against a transaction-level model; directed cases pin literal values.
module tb_fetch_unit;

  localparam int unsigned N   = 3;
  localparam int unsigned TMO = 4;
  localparam logic [31:0] RST_PC [N] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h1000_0000};
`ifdef FETCH_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        ack, stall, jump, beq, bne, zero;
  logic [31:0] rdata;

  logic        req_o   [N];
  logic        valid_o [N];
  logic        fault_o [N];
  logic [31:0] addr_o  [N];
  logic [31:0] pc_o    [N];
  logic [31:0] pc4_o   [N];
  logic [31:0] instr_o [N];
  logic [5:0]  opc_o   [N];

  always #5 i_clk = ~i_clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    fetch_unit_if bus ();
    assign bus.i_imem_ack   = ack;
    assign bus.i_imem_rdata = rdata;
    assign bus.i_stall      = stall;
    assign bus.i_jump       = jump;
    assign bus.i_beq        = beq;
    assign bus.i_bne        = bne;
    assign bus.i_zero       = zero;
    fetch_unit #(.RESET_PC(RST_PC[g]), .TIMEOUT_CYCLES(TMO)) u_dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
    );
    assign req_o[g]   = bus.o_imem_req;
    assign valid_o[g] = bus.o_instr_valid;
    assign fault_o[g] = bus.o_fault;
    assign addr_o[g]  = bus.o_imem_addr;
    assign pc_o[g]    = bus.o_pc;
    assign pc4_o[g]   = bus.o_pc_plus4;
    assign instr_o[g] = bus.o_instr;
    assign opc_o[g]   = bus.o_opcode;
  end

  int n_chk = 0;
  int n_err = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 = post-reset cycle, 1 = waiting for memory, 2 = instruction executing, 3 = halted
  int          ph;
  int          m_wait;
  logic [31:0] m_instr;
  logic [31:0] m_pc [N];

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w,
                                          input logic j, input logic b, input logic n, input logic z);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    if (j) return {seq[31:28], w[25:0], 2'b00};
    if ((b && z) || (n && !z)) begin
      off = int'($signed(w[15:0])) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ph      <= 0;
      m_wait  <= 0;
      m_instr <= '0;
      for (int k = 0; k < N; k++) m_pc[k] <= RST_PC[k];
    end else if (ph == 0) begin
      ph <= 1;
    end else if (ph == 1) begin
      if (ack) begin
        m_instr <= rdata;
        m_wait  <= 0;
        ph      <= 2;
      end else begin
        m_wait <= m_wait + 1;
        if (TIMEOUT_ON && (m_wait + 1 >= int'(TMO))) ph <= 3;
      end
    end else if (ph == 2 && !stall) begin
      for (int k = 0; k < N; k++) m_pc[k] <= next_pc(m_pc[k], m_instr, jump, beq, bne, zero);
      ph <= 1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge i_clk) begin
    if (armed) begin
      for (int k = 0; k < N; k++) begin
        chk($sformatf("req[%0d]", k),   32'(req_o[k]),   32'(ph == 1));
        chk($sformatf("valid[%0d]", k), 32'(valid_o[k]), 32'(ph == 2));
        chk($sformatf("fault[%0d]", k), 32'(fault_o[k]), 32'(ph == 3));
        chk($sformatf("pc[%0d]", k),    pc_o[k],         m_pc[k]);
        chk($sformatf("addr[%0d]", k),  addr_o[k],       m_pc[k]);
        chk($sformatf("pc4[%0d]", k),   pc4_o[k],        m_pc[k] + 32'd4);
        chk($sformatf("instr[%0d]", k), instr_o[k],      m_instr);
        chk($sformatf("opc[%0d]", k),   32'(opc_o[k]),   32'(m_instr[31:26]));
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic idle_ctl();
    jump = 1'bx; beq = 1'bx; bne = 1'bx; zero = 1'bx;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; ack = 1'b0; stall = 1'b0; idle_ctl();
    step(); step();
    i_rst_n = 1'b1;
    step();
  endtask

  // Starts in a fetch cycle; ends in the first fetch cycle of the following instruction
  task automatic run_instr(input logic [31:0] w, input int lat, input int stl,
                           input logic j, input logic b, input logic n, input logic z);
    ack = 1'b0;
    repeat (lat) step();
    ack = 1'b1; rdata = w;
    step();
    ack = 1'b0; rdata = $urandom;
    jump = j; beq = b; bne = n; zero = z;
    stall = 1'b1;
    repeat (stl) step();
    stall = 1'b0;
    step();
    idle_ctl();
  endtask

  logic [31:0] w;

  initial begin
    i_rst_n = 1'b0; ack = 1'b0; stall = 1'b0; rdata = '0; idle_ctl();
    step();
    armed = 1'b1;

    // Reset release with immediate ack of an addi
    do_reset();
    chk("t1_addr_first", addr_o[0], 32'h0000_0000);
    chk("t1_req_first", 32'(req_o[0]), 32'd1);
    ack = 1'b1; rdata = 32'h2008_0005;
    step();
    ack = 1'b0;
    chk("t1_valid", 32'(valid_o[0]), 32'd1);
    chk("t1_pc", pc_o[0], 32'h0000_0000);
    chk("t1_opcode", 32'(opc_o[0]), 32'h0000_0008);
    jump = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0;
    step();
    idle_ctl();
    chk("t1_valid_one_cycle", 32'(valid_o[0]), 32'd0);
    chk("t1_next_addr", addr_o[0], 32'h0000_0004);
    chk("wrap_second_addr", addr_o[1], 32'h0000_0000);

    // Reset asserted mid-fetch drops the request at once
    step();
    i_rst_n = 1'b0;
    #1;
    chk("rst_req_drop", 32'(req_o[0]), 32'd0);
    chk("rst_pc0", pc_o[0], 32'h0000_0000);
    chk("rst_pc1", pc_o[1], 32'hFFFF_FFFC);
    step();
    i_rst_n = 1'b1;
    step();

    // Jump has priority over bne; instance 2 executes at 0x1000_0000
    run_instr(32'h0800_0040, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("jump_addr_hi", addr_o[2], 32'h1000_0100);
    chk("jump_addr_lo", addr_o[0], 32'h0000_0100);

    // Walk to 0x10, then beq taken / jump back / beq not taken / beq+bne together
    do_reset();
    for (int i = 0; i < 4; i++) run_instr(32'h0000_0020, $urandom_range(0, 2), 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("walk_addr", addr_o[0], 32'h0000_0010);
    run_instr(32'h1109_FFFC, 1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("beq_taken", addr_o[0], 32'h0000_0004);
    run_instr(32'h0800_0004, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("jump_back", addr_o[0], 32'h0000_0010);
    run_instr(32'h1109_FFFC, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("beq_not_taken", addr_o[0], 32'h0000_0014);
    run_instr(32'h1000_0003, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("beq_bne_or", addr_o[0], 32'h0000_0024);

    // Three stall cycles; an ack pulse during EXEC is ignored
    w = 32'h8C01_0008;
    ack = 1'b1; rdata = w;
    step();
    ack = 1'b0; stall = 1'b1;
    jump = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid", 32'(valid_o[0]), 32'd1);
      chk("stall_pc", pc_o[0], 32'h0000_0024);
      chk("stall_noreq", 32'(req_o[0]), 32'd0);
      if (c == 1) begin ack = 1'b1; rdata = 32'hDEAD_BEEF; end
      step();
      ack = 1'b0;
    end
    chk("stall_valid_4th", 32'(valid_o[0]), 32'd1);
    chk("stall_instr_kept", instr_o[0], 32'h8C01_0008);
    stall = 1'b0;
    step();
    idle_ctl();
    chk("stall_release_valid", 32'(valid_o[0]), 32'd0);
    chk("stall_next_addr", addr_o[0], 32'h0000_0028);

`ifdef FETCH_TIMEOUT_EN
    // No ack: fault after four fetch cycles, held until reset
    do_reset();
    ack = 1'b0;
    repeat (3) step();
    chk("tmo_not_yet", 32'(fault_o[0]), 32'd0);
    step();
    chk("tmo_fault", 32'(fault_o[0]), 32'd1);
    chk("tmo_req_low", 32'(req_o[0]), 32'd0);
    ack = 1'b1;
    repeat (3) step();
    ack = 1'b0;
    chk("tmo_fault_held", 32'(fault_o[0]), 32'd1);
    chk("tmo_valid_low", 32'(valid_o[0]), 32'd0);
`endif

    // Randomized traffic with occasional resets and X on controls outside EXEC
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        ack   = ($urandom_range(0, 2) == 0);
        rdata = $urandom;
        stall = ($urandom_range(0, 2) == 0);
        if (ph == 2) begin
          jump = ($urandom_range(0, 5) == 0);
          beq  = $urandom_range(0, 1) != 0;
          bne  = $urandom_range(0, 1) != 0;
          zero = $urandom_range(0, 1) != 0;
        end else begin
          idle_ctl();
        end
        step();
      end
    end

    armed = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
